// File: rtl/memory_stage.sv
// Memory pipeline stage: data memory, stack pointer, I/O ports and the registered write-back select.
// Define MEM_STACK_CHECK_EN to block stack overflow/underflow and pulse stack_err instead of wrapping sp.
module memory_stage #(
  parameter int ADDR_WIDTH = 11,
  parameter int SP_INIT    = 2**ADDR_WIDTH - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            ctrl_in,
  input  logic [15:0]           alu_data,
  input  logic [15:0]           read_data2,
  input  logic [2:0]            write_add_in,
  input  logic [15:0]           in_port,
  output logic [15:0]           wb_data,
  output logic                  wb_reg_write,
  output logic [2:0]            wb_write_add,
  output logic [15:0]           out_port,
  output logic [ADDR_WIDTH-1:0] sp,
  output logic                  stack_err
);

  localparam int DATA_W = 16;
  localparam int DEPTH  = 2**ADDR_WIDTH;

  logic memw, memr, mtr, reg_write, in_sel, out_en, stack_op, push;
  assign memw      = ctrl_in[7];
  assign memr      = ctrl_in[6];
  assign mtr       = ctrl_in[5];
  assign reg_write = ctrl_in[4];
  assign in_sel    = ctrl_in[3];
  assign out_en    = ctrl_in[2];
  assign stack_op  = ctrl_in[1];
  assign push      = ctrl_in[0];

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] addr_lo;
  logic                  unused_addr_bits;
  assign addr_lo          = alu_data[ADDR_WIDTH-1:0];
  assign unused_addr_bits = ^alu_data[DATA_W-1:ADDR_WIDTH];

  logic [ADDR_WIDTH-1:0] sp_inc, sp_dec;
  assign sp_inc = sp + ADDR_WIDTH'(1);
  assign sp_dec = sp - ADDR_WIDTH'(1);

  logic push_req, pop_req, stack_fault;
  assign push_req = stack_op & push & memw;
  assign pop_req  = stack_op & ~push & memr & ~memw;

`ifdef MEM_STACK_CHECK_EN
  assign stack_fault = (push_req && (sp == '0)) || (pop_req && (sp == '1));
`else
  assign stack_fault = 1'b0;
`endif

  logic push_ok, pop_ok, wr_en, rd_en;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  assign push_ok = push_req & ~stack_fault;
  assign pop_ok  = pop_req & ~stack_fault;
  // A simultaneous write and read is resolved in favour of the write.
  assign wr_en   = (memw & ~stack_op) | push_ok;
  assign rd_en   = (memr & ~memw & ~stack_op) | pop_ok;
  assign wr_addr = stack_op ? sp : addr_lo;
  assign rd_addr = stack_op ? sp_inc : addr_lo;

  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem[wr_addr] <= read_data2;
    end
  end

  // Stage boundary: EM inputs -> MW outputs, one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp           <= ADDR_WIDTH'(SP_INIT);
      wb_data      <= '0;
      wb_reg_write <= 1'b0;
      wb_write_add <= '0;
      out_port     <= '0;
      stack_err    <= 1'b0;
    end else begin
      if (pop_ok) begin
        sp <= sp_inc;
      end else if (push_ok) begin
        sp <= sp_dec;
      end

      if (in_sel) begin
        wb_data <= in_port;
      end else if (mtr && rd_en) begin
        wb_data <= mem[rd_addr];
      end else begin
        wb_data <= alu_data;
      end

      wb_reg_write <= reg_write;
      wb_write_add <= write_add_in;
      if (out_en) begin
        out_port <= read_data2;
      end
      stack_err <= stack_fault;
    end
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter ADDR_WIDTH, default 11, word-address width of data memory (2^ADDR_WIDTH x 16-bit words).
REQ-002 Parameter SP_INIT, default 2^ADDR_WIDTH-1, stack pointer value after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ctrl_in  input  8  control from EM buffer: [7]MEMW [6]MEMR [5]MTR [4]RegWrite [3]In [2]Out [1]StackOp [0]Push.
REQ-006 alu_data  input  16  ALU result; memory address for non-stack accesses.
REQ-007 read_data2  input  16  store data for MEMW/Push and data for Out.
REQ-008 write_add_in  input  3  destination register index.
REQ-009 in_port  input  16  external input port value.
REQ-010 wb_data  output  16  registered write-back data toward MW buffer.
REQ-011 wb_reg_write  output  1  registered RegWrite toward MW buffer.
REQ-012 wb_write_add  output  3  registered destination register index.
REQ-013 out_port  output  16  output port register.
REQ-014 sp  output  ADDR_WIDTH  current stack pointer.
REQ-015 stack_err  output  1  one-cycle pulse on stack overflow/underflow (see Configuration).

Function
REQ-016 Non-stack write (MEMW=1, StackOp=0): mem[alu_data[ADDR_WIDTH-1:0]] <= read_data2 at the edge; upper address bits ignored.
REQ-017 Non-stack read (MEMR=1, StackOp=0): read data from mem[alu_data[ADDR_WIDTH-1:0]] is available in wb_data one cycle later when MTR=1.
REQ-018 Push (StackOp=1, Push=1, MEMW=1): mem[sp] <= read_data2; sp <= sp-1, same edge.
REQ-019 Pop (StackOp=1, Push=0, MEMR=1): sp <= sp+1; mem[sp+1] is read and reaches wb_data one cycle later when MTR=1.
REQ-020 StackOp=1 with neither MEMW nor MEMR: no memory access, sp unchanged.
REQ-021 MEMW and MEMR both 1: write performed, read suppressed; wb_data takes alu_data.
REQ-022 wb_data select, registered: In=1 -> in_port; else MTR=1 -> memory read data; else alu_data.
REQ-023 wb_reg_write and wb_write_add register ctrl_in[4] and write_add_in every cycle; total stage latency 1 cycle.
REQ-024 Out=1: out_port <= read_data2 at the edge; otherwise out_port holds.
REQ-025 Read of an address written in the previous cycle returns the new data.
REQ-026 ctrl_in all zero: memory, sp, out_port unchanged; wb_data <= alu_data, wb_reg_write <= 0.

Reset
REQ-027 reset=1 at an edge: sp <= SP_INIT, wb_data <= 0, wb_reg_write <= 0, wb_write_add <= 0, out_port <= 0, stack_err <= 0.
REQ-028 reset has priority over every ctrl_in operation in the same cycle; no memory write occurs during reset.
REQ-029 Memory contents are not cleared by reset.

Configuration
REQ-030 Macro MEM_STACK_CHECK_EN defined: Push with sp==0 or Pop with sp==2^ADDR_WIDTH-1 performs no memory access, leaves sp unchanged, drives wb_data <= alu_data, pulses stack_err for one cycle.
REQ-031 MEM_STACK_CHECK_EN undefined: sp wraps modulo 2^ADDR_WIDTH, access proceeds, stack_err tied 0.

Verification
REQ-032 Reset then ctrl_in=0 -> sp=0x7FF, wb_reg_write=0, out_port=0.
REQ-033 MEMW, alu_data=0x0010, read_data2=0xBEEF; next cycle MEMR+MTR+RegWrite, alu_data=0x0010, write_add_in=5 -> one cycle later wb_data=0xBEEF, wb_reg_write=1, wb_write_add=5.
REQ-034 Push 0x1234, Push 0x5678, Pop+MTR, Pop+MTR -> sp 0x7FF->0x7FE->0x7FD->0x7FE->0x7FF; wb_data 0x5678 then 0x1234.
REQ-035 In=1, in_port=0xA5A5; Out=1, read_data2=0x00FF -> wb_data=0xA5A5; out_port=0x00FF, held afterwards.
REQ-036 Pop at sp=0x7FF: with MEM_STACK_CHECK_EN stack_err=1 one cycle, sp=0x7FF; without it sp=0x000, stack_err=0.
REQ-037 Push issued in same cycle as reset=1 -> sp=0x7FF, mem[0x7FF] unchanged.
